lsu_pipelined: RTL

LSU_PIPELINED -- requirements
Module: lsu_pipelined

---
 rtl/lsu_pipelined.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_pipelined.sv
// Pipelined RISC-V load/store unit with an Avalon-MM master port. Loads are tracked
// in an in-order tag FIFO; returned data is aligned and extended into a response FIFO.
module lsu_pipelined #(
  parameter int DW              = 32,
  parameter int AW              = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_read,
  input  logic            req_write,
  input  logic [2:0]      req_opcode,
  input  logic [AW-1:0]   req_address,
  input  logic [DW-1:0]   req_writedata,
  output logic            req_ready,
  output logic            exc_load_misaligned,
  output logic            exc_store_misaligned,
  output logic            av_read,
  output logic            av_write,
  output logic [AW-1:0]   av_address,
  output logic [DW/8-1:0] av_byteenable,
  output logic [DW-1:0]   av_writedata,
  input  logic            av_waitrequest,
  input  logic            av_readdatavalid,
  input  logic [DW-1:0]   av_readdata,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_data,
  input  logic            rsp_ready,
  output logic            lsu_busy
);

  localparam int BEW  = DW / 8;
  localparam int OFFW = $clog2(BEW);
  localparam int PW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW   = 3 + OFFW;

  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return |a[1:0];
      default: return |a;
    endcase
  endfunction

  function automatic logic [BEW-1:0] lane_mask(input logic [1:0] sz, input logic [OFFW-1:0] off);
    logic [2*BEW-1:0] m;
    case (sz)
      2'd0:    m = (2*BEW)'(1);
      2'd1:    m = (2*BEW)'(3);
      2'd2:    m = (2*BEW)'(15);
      default: m = {{BEW{1'b0}}, {BEW{1'b1}}};
    endcase
    m = m << off;
    return m[BEW-1:0];
  endfunction

  // Move the addressed lane down to bit 0, then sign- or zero-extend by shifting
  // the field to the top and back down.
  function automatic logic [DW-1:0] load_extend(input logic [DW-1:0] raw,
                                                input logic [2:0] op,
                                                input logic [OFFW-1:0] off);
    logic        [DW-1:0] lane;
    logic signed [DW-1:0] lane_s;
    int                   pad;
    lane = raw >> {off, 3'b000};
    case (op[1:0])
      2'd0:    pad = DW - 8;
      2'd1:    pad = DW - 16;
      2'd2:    pad = DW - 32;
      default: pad = 0;
    endcase
    lane   = lane << pad;
    lane_s = lane;
    return op[2] ? (lane >> pad) : $unsigned(lane_s >>> pad);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  logic            is_rd, is_wr, mis, credit, load_acc, rsp_pop, vld_p0;
  logic [OFFW-1:0] req_off;
  logic [TW-1:0]   tag_head;
  logic [DW-1:0]   ld_data_p0;

  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CW-1:0]   tag_cnt_q, tag_cnt_d;
  logic [PW-1:0]   rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [CW-1:0]   rsp_cnt_q, rsp_cnt_d;
  logic [TW-1:0]   tag_mem_q [MAX_OUTSTANDING];
  logic [DW-1:0]   rsp_mem_q [MAX_OUTSTANDING];

  // Request decode: read wins when both strobes are high.
  assign is_rd   = req_valid & req_read;
  assign is_wr   = req_valid & req_write & ~req_read;
  assign req_off = req_address[OFFW-1:0];
  assign mis     = misaligned(req_opcode[1:0], req_address[2:0]);
  assign credit  = count_q < CW'(MAX_OUTSTANDING);

  assign exc_load_misaligned  = is_rd & mis;
  assign exc_store_misaligned = is_wr & mis;

  assign av_read       = ~rst & is_rd & ~mis & credit;
  assign av_write      = ~rst & is_wr & ~mis;
  assign av_address    = {req_address[AW-1:OFFW], {OFFW{1'b0}}};
  assign av_byteenable = lane_mask(req_opcode[1:0], req_off);
  assign av_writedata  = req_writedata << {req_off, 3'b000};

  always_comb begin
    req_ready = 1'b1;
    if (rst)
      req_ready = 1'b0;
    else if ((is_rd | is_wr) & mis)
      req_ready = 1'b1;
    else if (is_wr)
      req_ready = ~av_waitrequest;
    else if (is_rd)
      req_ready = ~av_waitrequest & credit;
  end

  assign load_acc = av_read & ~av_waitrequest;
  assign rsp_valid = ~rst & (rsp_cnt_q != '0);
  assign rsp_data  = rsp_mem_q[rsp_rd_q];
  assign rsp_pop   = rsp_valid & rsp_ready;
  assign lsu_busy  = ~rst & (count_q != '0);

  // Stage p0: returning read data meets its tag; readdatavalid with no tag is dropped.
  assign tag_head   = tag_mem_q[tag_rd_q];
  assign vld_p0     = av_readdatavalid & (tag_cnt_q != '0);
  assign ld_data_p0 = load_extend(av_readdata, tag_head[TW-1 -: 3], tag_head[OFFW-1:0]);

  always_comb begin
    count_d = count_q;
    if (load_acc && !rsp_pop)
      count_d = count_q + 1'b1;
    else if (!load_acc && rsp_pop)
      count_d = count_q - 1'b1;

    tag_wr_d  = load_acc ? ptr_inc(tag_wr_q) : tag_wr_q;
    tag_rd_d  = vld_p0   ? ptr_inc(tag_rd_q) : tag_rd_q;
    tag_cnt_d = tag_cnt_q;
    if (load_acc && !vld_p0)
      tag_cnt_d = tag_cnt_q + 1'b1;
    else if (!load_acc && vld_p0)
      tag_cnt_d = tag_cnt_q - 1'b1;

    rsp_wr_d  = vld_p0  ? ptr_inc(rsp_wr_q) : rsp_wr_q;
    rsp_rd_d  = rsp_pop ? ptr_inc(rsp_rd_q) : rsp_rd_q;
    rsp_cnt_d = rsp_cnt_q;
    if (vld_p0 && !rsp_pop)
      rsp_cnt_d = rsp_cnt_q + 1'b1;
    else if (!vld_p0 && rsp_pop)
      rsp_cnt_d = rsp_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      tag_cnt_q <= '0;
      rsp_wr_q  <= '0;
      rsp_rd_q  <= '0;
      rsp_cnt_q <= '0;
    end else begin
      count_q   <= count_d;
      tag_wr_q  <= tag_wr_d;
      tag_rd_q  <= tag_rd_d;
      tag_cnt_q <= tag_cnt_d;
      rsp_wr_q  <= rsp_wr_d;
      rsp_rd_q  <= rsp_rd_d;
      rsp_cnt_q <= rsp_cnt_d;
    end
  end

  // Stage p1: FIFO storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (load_acc)
      tag_mem_q[tag_wr_q] <= {req_opcode, req_off};
    if (vld_p0)
      rsp_mem_q[rsp_wr_q] <= ld_data_p0;
  end

endmodule
